tx_gearbox_6664b: RTL and testbench

- TX gearbox between the 64b/66b encoder (plus scrambler) and the 32-bit transceiver data port.
- Accepts one 32-bit half-block per cycle, with a 2-bit sync header on each block's first half. Emits a continuous 32-bit serial-order stream.
- The 66:64 rate mismatch is absorbed by pausing the upstream pipeline 1 cycle in every 33.
- Drives the i_tx_pause input of the encoder.

---
 rtl/tx_gearbox_6664b_pkg.sv | 17 +
 rtl/tx_gearbox_6664b_if.sv | 21 ++
 rtl/tx_gearbox_6664b.sv | 77 +++++++
 tb/tb_tx_gearbox_6664b.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tx_gearbox_6664b_pkg.sv
// Shared constants and types for the 64b/66b TX gearbox.
package tx_gearbox_6664b_pkg;

    localparam int GEARBOX_DATA_W = 32;
    localparam int GEARBOX_SEQ_W  = 6;
    localparam logic [GEARBOX_SEQ_W-1:0] GEARBOX_SEQ_MAX = 6'd32;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTL  = 2'b10;

    typedef enum logic [1:0] {
        CYC_HALF0 = 2'd0,
        CYC_HALF1 = 2'd1,
        CYC_PAUSE = 2'd2
    } gb_cyc_e;

endpackage

// File: rtl/tx_gearbox_6664b_if.sv
// Encoder-side half-block inputs and transceiver-side gearboxed outputs.
interface tx_gearbox_6664b_if;
    import tx_gearbox_6664b_pkg::*;

    logic [GEARBOX_DATA_W-1:0] txd;
    logic [1:0]                tx_header;
    logic [GEARBOX_DATA_W-1:0] line_txd;
    logic                      tx_pause;
    logic [GEARBOX_SEQ_W-1:0]  tx_seq;

    modport master (
        output txd, tx_header,
        input  line_txd, tx_pause, tx_seq
    );

    modport slave (
        input  txd, tx_header,
        output line_txd, tx_pause, tx_seq
    );

endinterface

// File: rtl/tx_gearbox_6664b.sv
// 66:64 TX gearbox packing {data, header} half-blocks into a continuous 32-bit stream.
// Latency 1 cycle (registered output); backpressure: pauses upstream one cycle in 33.
module tx_gearbox_6664b
    import tx_gearbox_6664b_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic               i_txc,
    input logic               i_reset,
    tx_gearbox_6664b_if.slave gb
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $fatal(1, "tx_gearbox_6664b: only DATA_WIDTH=32 is supported");
    end

    logic [GEARBOX_SEQ_W-1:0]  seq;
    logic [GEARBOX_SEQ_W-1:0]  seq_nxt;
    logic [5:0]                fill;
    logic [5:0]                fill_nxt;
    logic [31:0]               resid;
    logic [31:0]               resid_nxt;
    logic [31:0]               txd_q;
    logic [31:0]               txd_nxt;
    logic [33:0]               stream;
    logic [63:0]               shifted;
    gb_cyc_e                   cyc;

    always_comb begin
        cyc       = CYC_PAUSE;
        stream    = '0;
        shifted   = '0;
        txd_nxt   = resid;
        resid_nxt = '0;
        fill_nxt  = '0;
        seq_nxt   = '0;

        if (seq != GEARBOX_SEQ_MAX) begin
            cyc = seq[0] ? CYC_HALF1 : CYC_HALF0;
        end

        unique case (cyc)
            CYC_HALF0: stream = {gb.txd, gb.tx_header};
            CYC_HALF1: stream = {2'b00, gb.txd};
            default:   stream = '0;
        endcase

        // New bits land directly above the fill-count valid residual bits.
        shifted = ({30'd0, stream} << fill) | {32'd0, resid};

        if (cyc != CYC_PAUSE) begin
            txd_nxt   = shifted[31:0];
            resid_nxt = shifted[63:32];
            fill_nxt  = (cyc == CYC_HALF0) ? fill + 6'd2 : fill;
            seq_nxt   = seq + 6'd1;
        end
    end

    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            seq   <= '0;
            fill  <= '0;
            resid <= '0;
            txd_q <= '0;
        end else begin
            seq   <= seq_nxt;
            fill  <= fill_nxt;
            resid <= resid_nxt;
            txd_q <= txd_nxt;
        end
    end

    assign gb.line_txd = txd_q;
    assign gb.tx_pause = (seq == GEARBOX_SEQ_MAX);
    assign gb.tx_seq   = seq;

endmodule

// File: tb/tb_tx_gearbox_6664b.sv
// Bench for tx_gearbox_6664b: bit-queue reference model plus directed vectors.
module tb_tx_gearbox_6664b;
    import tx_gearbox_6664b_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_gearbox_6664b_if bus();

    tx_gearbox_6664b #(.DATA_WIDTH(32)) dut (
        .i_txc   (clk),
        .i_reset (rst),
        .gb      (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference: every transmitted bit in order, consumed 32 per cycle.
    int          m_cyc;
    logic [31:0] m_out;
    bit          q[$];

    bit            capture;
    logic [1055:0] frame_got;
    logic [1055:0] frame_exp;

    typedef struct {
        logic [1:0]  h;
        logic [31:0] d;
        logic [31:0] exp_txd;
        logic [5:0]  exp_seq;
        logic        exp_pause;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at model cycle %0d: got %h, expected %h", name, m_cyc, got, exp);
        end
    endtask

    // Check the current cycle's outputs, drive this cycle's inputs, advance one clock.
    task automatic step(input logic r, input logic [31:0] d, input logic [1:0] h);
        int          s;
        logic [31:0] nxt;
        s = m_cyc % 33;
        chk("txd", bus.line_txd, m_out);
        chk("seq", 32'(bus.tx_seq), 32'(s));
        chk("pause", 32'(bus.tx_pause), 32'(s == 32));
        if (capture && m_cyc >= 1 && m_cyc <= 33)
            frame_got[(m_cyc-1)*32 +: 32] = bus.line_txd;

        bus.txd       = d;
        bus.tx_header = h;
        rst           = r;

        if (r) begin
            q.delete();
            m_out = '0;
            m_cyc = 0;
        end else begin
            if (s < 32) begin
                if (s % 2 == 0) begin
                    q.push_back(h[0]);
                    q.push_back(h[1]);
                end
                for (int i = 0; i < 32; i++) q.push_back(d[i]);
                if (capture && m_cyc < 32) begin
                    if (s % 2 == 0) begin
                        frame_exp[(s/2)*66 +: 2]      = h;
                        frame_exp[(s/2)*66 + 2 +: 32] = d;
                    end else begin
                        frame_exp[(s/2)*66 + 34 +: 32] = d;
                    end
                end
            end
            nxt = '0;
            for (int i = 0; i < 32; i++)
                if (q.size() > 0) nxt[i] = q.pop_front();
            m_out = nxt;
            m_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit beef);
        for (int k = 0; k < n; k++) begin
            if (m_cyc % 33 == 32)
                step(1'b0, beef ? 32'hDEADBEEF : 32'h0, beef ? 2'b11 : 2'b00);
            else
                step(1'b0, $urandom, 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        tbl[0] = '{2'b10, 32'h0000_0001, 32'h0000_0000, 6'd0, 1'b0};
        tbl[1] = '{2'b01, 32'h0000_0000, 32'h0000_0006, 6'd1, 1'b0};
        tbl[2] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 6'd2, 1'b0};
        tbl[3] = '{2'b00, 32'h0000_0000, 32'hFFFF_FFF4, 6'd3, 1'b0};
        tbl[4] = '{2'b00, 32'h0000_0000, 32'h0000_000F, 6'd4, 1'b0};

        bus.txd       = '0;
        bus.tx_header = '0;
        m_cyc         = 0;
        m_out         = '0;
        capture       = 1'b0;
        frame_got     = '0;
        frame_exp     = '0;
        repeat (3) @(posedge clk);
        #1;

        // Directed bit-order vectors straight after reset release.
        for (int i = 0; i < 5; i++) begin
            chk("tbl_txd", bus.line_txd, tbl[i].exp_txd);
            chk("tbl_seq", 32'(bus.tx_seq), 32'(tbl[i].exp_seq));
            chk("tbl_pause", 32'(bus.tx_pause), 32'(tbl[i].exp_pause));
            step(1'b0, tbl[i].d, tbl[i].h);
        end
        run(80, 1'b0);

        // One full frame: 16 blocks reconstructed from 33 output words.
        step(1'b1, 32'h0, 2'b00);
        capture = 1'b1;
        run(34, 1'b0);
        capture = 1'b0;
        nvec++;
        if (frame_got !== frame_exp) begin
            bit shown;
            nerr++;
            shown = 1'b0;
            for (int w = 0; w < 33; w++) begin
                if (!shown && frame_got[w*32 +: 32] !== frame_exp[w*32 +: 32]) begin
                    $display("FAIL frame word %0d: got %h, expected %h",
                             w, frame_got[w*32 +: 32], frame_exp[w*32 +: 32]);
                    shown = 1'b1;
                end
            end
        end

        run(70, 1'b1);

        // Reset at seq 17, then at a pause cycle.
        while (m_cyc % 33 != 17) run(1, 1'b0);
        step(1'b1, $urandom, 2'($urandom_range(0, 3)));
        run(70, 1'b0);
        while (m_cyc % 33 != 32) run(1, 1'b0);
        step(1'b1, 32'hDEADBEEF, 2'b11);
        run(40, 1'b1);

        run(10000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
